// File: rtl/axil_arb_rd.sv
// rtl/axil_arb_rd.sv - two-master AXI-Lite read arbiter with slave-window decode
// Optional round-robin contention resolution when AXIL_ARB_RD_RR_EN is defined.
module axil_arb_rd #(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] SLV_BASE       = 32'h0000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] SLV_SIZE       = 32'h0001_0000
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr_0,
    input  logic                      s_axil_arvalid_0,
    output logic                      s_axil_arready_0,
    output logic [AXI_DATA_WIDTH-1:0] s_axil_rdata_0,
    output logic [1:0]                s_axil_rresp_0,
    output logic                      s_axil_rvalid_0,
    input  logic                      s_axil_rready_0,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr_1,
    input  logic                      s_axil_arvalid_1,
    output logic                      s_axil_arready_1,
    output logic [AXI_DATA_WIDTH-1:0] s_axil_rdata_1,
    output logic [1:0]                s_axil_rresp_1,
    output logic                      s_axil_rvalid_1,
    input  logic                      s_axil_rready_1,
    output logic [AXI_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready,
    output logic                      slv_invalid,
    output logic                      grant,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    // One extra bit keeps BASE+SIZE from wrapping at the top of the address space.
    localparam logic [AXI_ADDR_WIDTH:0] BASE_EXT  = {1'b0, SLV_BASE};
    localparam logic [AXI_ADDR_WIDTH:0] LIMIT_EXT = {1'b0, SLV_BASE} + {1'b0, SLV_SIZE};

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   slv_invalid_q, slv_invalid_d;
    logic   busy_q, busy_d;

    logic                      req_any;
    logic                      winner;
    logic [AXI_ADDR_WIDTH-1:0] win_addr;
    logic [AXI_ADDR_WIDTH-1:0] sel_araddr;
    logic                      sel_arvalid;
    logic                      sel_rready;
    logic                      in_addr;
    logic                      in_data;

    always_comb begin
        req_any = s_axil_arvalid_0 | s_axil_arvalid_1;
`ifdef AXIL_ARB_RD_RR_EN
        if (s_axil_arvalid_0 && s_axil_arvalid_1) begin
            winner = ~last_grant_q;
        end else begin
            winner = ~s_axil_arvalid_0;
        end
`else
        winner = ~s_axil_arvalid_0;
`endif
        win_addr    = winner ? s_axil_araddr_1 : s_axil_araddr_0;
        sel_araddr  = grant_q ? s_axil_araddr_1 : s_axil_araddr_0;
        sel_arvalid = grant_q ? s_axil_arvalid_1 : s_axil_arvalid_0;
        sel_rready  = grant_q ? s_axil_rready_1 : s_axil_rready_0;
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        slv_invalid_d = slv_invalid_q;
        busy_d        = busy_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d       = ADDR;
                    grant_d       = winner;
                    last_grant_d  = winner;
                    busy_d        = 1'b1;
                    slv_invalid_d = !(({1'b0, win_addr} >= BASE_EXT) &&
                                      ({1'b0, win_addr} <  LIMIT_EXT));
                end
            end
            ADDR: begin
                if (sel_arvalid && m_axil_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m_axil_rvalid && sel_rready) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            slv_invalid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            slv_invalid_q <= slv_invalid_d;
            busy_q        <= busy_d;
        end
    end

    // Routing is gated by the registered phase so nothing leaks outside ADDR/DATA.
    always_comb begin
        in_addr = (state_q == ADDR);
        in_data = (state_q == DATA);

        m_axil_araddr  = in_addr ? sel_araddr : '0;
        m_axil_arvalid = in_addr & sel_arvalid;
        m_axil_rready  = in_data & sel_rready;

        s_axil_arready_0 = in_addr & ~grant_q & m_axil_arready;
        s_axil_arready_1 = in_addr &  grant_q & m_axil_arready;
        s_axil_rvalid_0  = in_data & ~grant_q & m_axil_rvalid;
        s_axil_rvalid_1  = in_data &  grant_q & m_axil_rvalid;
        s_axil_rdata_0   = (in_data & ~grant_q) ? m_axil_rdata : '0;
        s_axil_rdata_1   = (in_data &  grant_q) ? m_axil_rdata : '0;
        s_axil_rresp_0   = (in_data & ~grant_q) ? m_axil_rresp : 2'b00;
        s_axil_rresp_1   = (in_data &  grant_q) ? m_axil_rresp : 2'b00;
    end

    assign grant       = grant_q;
    assign slv_invalid = slv_invalid_q;
    assign busy        = busy_q;

endmodule
